aes_job_sequencer: RTL

//  Sequences top_aes over a multi-block job without CPU polling. Software writes a base address and a

---
 rtl/aes_seq_pkg.sv | 35 +++
 rtl/aes_seq_csr.sv | 102 ++++++++++
 rtl/aes_job_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES job sequencer: FSM encoding, CSR map,
// top_aes slave register offsets and STATUS/CTRL bit positions.
package aes_seq_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_WR_PTR = 3'd1;
    localparam seq_state_t ST_WR_GO  = 3'd2;
    localparam seq_state_t ST_GAP    = 3'd3;
    localparam seq_state_t ST_POLL   = 3'd4;
    localparam seq_state_t ST_NEXT   = 3'd5;
    localparam seq_state_t ST_FIN    = 3'd6;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_BASE   = 2'd2;
    localparam logic [1:0] CSR_COUNT  = 2'd3;

    localparam logic [3:0] AES_REG_START  = 4'd0;
    localparam logic [3:0] AES_REG_STATUS = 4'd1;
    localparam logic [3:0] AES_REG_PTR    = 4'd2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_CLEAR  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_BDONE_LSB = 16;

endpackage

// File: rtl/aes_seq_csr.sv
// CSR slave of the AES job sequencer: register decode, zero-wait readback,
// BASE/COUNT storage and the sticky DONE/ERR/TIMEOUT/IRQ_EN bits.
module aes_seq_csr
    import aes_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              csr_waitrequest,
    input  logic              busy,
    input  logic [CNT_W-1:0]  blocks_done,
    input  logic              done_set,
    input  logic              done_clr,
    input  logic              err_set,
    input  logic              tmo_set,
    output logic [ADDR_W-1:0] base,
    output logic [CNT_W-1:0]  count,
    output logic              start,
    output logic              abort,
    output logic              irq
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [31:0]       rd_mux;
    logic              ctrl_wr;
    logic              clr;

    always_comb begin
        ctrl_wr  = csr_write && (csr_address == CSR_CTRL);
        clr      = ctrl_wr && csr_writedata[CTRL_CLEAR];
        start    = ctrl_wr && csr_writedata[CTRL_START];
        abort    = ctrl_wr && csr_writedata[CTRL_ABORT];
        irq_en_d = ctrl_wr ? csr_writedata[CTRL_IRQ_EN] : irq_en_q;

        base_d  = base_q;
        count_d = count_q;
        if (csr_write && !busy && (csr_address == CSR_BASE))
            base_d = csr_writedata[ADDR_W-1:0];
        if (csr_write && !busy && (csr_address == CSR_COUNT))
            count_d = csr_writedata[CNT_W-1:0];

        // Sets are applied after clears so a set in the same cycle wins.
        done_d = done_set | (done_q & ~clr & ~done_clr);
        err_d  = err_set  | (err_q  & ~clr);
        tmo_d  = tmo_set  | (tmo_q  & ~clr);

        rd_mux = '0;
        case (csr_address)
            CSR_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
            CSR_STATUS: begin
                rd_mux[STAT_BUSY]    = busy;
                rd_mux[STAT_DONE]    = done_q;
                rd_mux[STAT_ERR]     = err_q;
                rd_mux[STAT_TIMEOUT] = tmo_q;
                rd_mux[31:STAT_BDONE_LSB] = 16'(blocks_done);
            end
            CSR_BASE:   rd_mux = 32'(base_q);
            default:    rd_mux = 32'(count_q);
        endcase
        readdata_d = csr_read ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            count_q    <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            base_q     <= base_d;
            count_q    <= count_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            readdata_q <= readdata_d;
        end
    end

    assign csr_readdata    = readdata_q;
    assign csr_waitrequest = 1'b0;
    assign base            = base_q;
    assign count           = count_q;
    assign irq             = irq_en_q & (done_q | err_q);

endmodule

// File: rtl/aes_job_sequencer.sv
// Walks top_aes through a multi-block job: pointer write, start, status polls, advance by STRIDE.
// Build option: define AES_SEQ_TIMEOUT_EN to add the per-block watchdog and STATUS[3] TIMEOUT.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int STRIDE   = 288,
    parameter int CNT_W    = 16,
    parameter int POLL_GAP = 4,
    parameter int TMO_CYC  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        csr_waitrequest,
    output logic [3:0]  aes_address,
    output logic        aes_read,
    output logic        aes_write,
    output logic [31:0] aes_writedata,
    input  logic [31:0] aes_readdata,
    input  logic        aes_waitrequest,
    output logic        irq
);

    localparam logic [CNT_W:0] ONE_EXT = 1;

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cur_ptr_q, cur_ptr_d;
    logic [CNT_W-1:0]  blocks_done_q, blocks_done_d;
    logic [31:0]       gap_cnt_q, gap_cnt_d;
    logic              abort_pend_q, abort_pend_d;

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic              start_pulse;
    logic              abort_pulse;
    logic              abort_now;
    logic              busy;
    logic              done_set;
    logic              done_clr;
    logic              err_set;
    logic              tmo_set;
    logic              tmo_hit;
    logic              gap_last;
    logic              unused_rdata;

    assign unused_rdata = ^aes_readdata[31:1];
    assign busy         = (state_q != ST_IDLE);
    assign abort_now    = abort_pend_q | abort_pulse;
    assign gap_last     = (POLL_GAP <= 1) || (gap_cnt_q >= 32'(POLL_GAP - 1));

    aes_seq_csr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_csr (
        .clk             (clk),
        .rst_n           (rst_n),
        .csr_address     (csr_address),
        .csr_read        (csr_read),
        .csr_write       (csr_write),
        .csr_writedata   (csr_writedata),
        .csr_readdata    (csr_readdata),
        .csr_waitrequest (csr_waitrequest),
        .busy            (busy),
        .blocks_done     (blocks_done_q),
        .done_set        (done_set),
        .done_clr        (done_clr),
        .err_set         (err_set),
        .tmo_set         (tmo_set),
        .base            (base),
        .count           (count),
        .start           (start_pulse),
        .abort           (abort_pulse),
        .irq             (irq)
    );

`ifdef AES_SEQ_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // Counts GAP/POLL cycles since the start command for this block was accepted.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_WR_GO && !aes_waitrequest)
            tmo_cnt_d = '0;
        else if ((state_q == ST_GAP || state_q == ST_POLL) && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + 32'd1;
    end

    assign tmo_hit = (tmo_cnt_q >= 32'(TMO_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cur_ptr_d     = cur_ptr_q;
        blocks_done_d = blocks_done_q;
        gap_cnt_d     = gap_cnt_q;
        done_set      = 1'b0;
        done_clr      = 1'b0;
        err_set       = 1'b0;
        tmo_set       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse && !abort_pulse) begin
                    if (count != '0) begin
                        state_d       = ST_WR_PTR;
                        cur_ptr_d     = base;
                        blocks_done_d = '0;
                        done_clr      = 1'b1;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            ST_WR_PTR: begin
                if (!aes_waitrequest) begin
                    state_d = abort_now ? ST_IDLE : ST_WR_GO;
                    err_set = abort_now;
                end
            end
            ST_WR_GO: begin
                if (!aes_waitrequest) begin
                    state_d   = abort_now ? ST_IDLE : ST_GAP;
                    err_set   = abort_now;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (abort_now || tmo_hit) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                    tmo_set = !abort_now;
                end else if (gap_last) begin
                    state_d = ST_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end
            ST_POLL: begin
                // An abort landing on a completing poll wins even if that poll reports done.
                if (!aes_waitrequest) begin
                    gap_cnt_d = '0;
                    if (abort_now) begin
                        state_d = ST_IDLE;
                        err_set = 1'b1;
                    end else if (aes_readdata[0]) begin
                        state_d = ST_NEXT;
                    end else if (tmo_hit) begin
                        state_d = ST_IDLE;
                        err_set = 1'b1;
                        tmo_set = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_NEXT: begin
                blocks_done_d = blocks_done_q + CNT_W'(1);
                cur_ptr_d     = cur_ptr_q + ADDR_W'(STRIDE);
                if (abort_now) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (({1'b0, blocks_done_q} + ONE_EXT) < {1'b0, count}) begin
                    state_d = ST_WR_PTR;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_set = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        abort_pend_d = busy && (state_d != ST_IDLE) && (abort_pend_q || abort_pulse);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_ptr_q     <= '0;
            blocks_done_q <= '0;
            gap_cnt_q     <= '0;
            abort_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_ptr_q     <= cur_ptr_d;
            blocks_done_q <= blocks_done_d;
            gap_cnt_q     <= gap_cnt_d;
            abort_pend_q  <= abort_pend_d;
        end
    end

    always_comb begin
        aes_write     = (state_q == ST_WR_PTR) || (state_q == ST_WR_GO);
        aes_read      = (state_q == ST_POLL);
        aes_address   = 4'd0;
        aes_writedata = 32'd0;
        case (state_q)
            ST_WR_PTR: begin
                aes_address   = AES_REG_PTR;
                aes_writedata = 32'(cur_ptr_q);
            end
            ST_WR_GO: begin
                aes_address   = AES_REG_START;
                aes_writedata = 32'h1;
            end
            ST_POLL:  aes_address = AES_REG_STATUS;
            default:  aes_address = 4'd0;
        endcase
    end

endmodule
